fifo_rd_rr_arbiter: RTL and testbench

Read-side scheduler that shares one downstream consumer among NUM_FIFOS async FIFOs, all in the rclk domain.
- Monitors each FIFO's registered rempty flag and grants one FIFO at a time, round-robin.
- Pops the granted FIFO through its rinc strobe, for up to BURST words per grant.
- Presents popped words on a single registered valid/ready output stage tagged with the source index.
- FIFO memories are asynchronous-read: rdata reflects raddr in the same cycle.

---
 rtl/fifo_rd_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_fifo_rd_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_rr_arbiter.sv
// Round-robin read scheduler sharing one consumer among several FIFOs in
// the rclk domain. Pops the granted FIFO for up to BURST words per grant
// and presents each word on a registered valid/ready stage tagged with its
// source index.
//
// Ports:
//   rclk, rrst       clock, synchronous active-high reset
//   fifo_rempty      registered empty flag per FIFO
//   fifo_rdata       async-read data per FIFO, FIFO i at [i*DSIZE +: DSIZE]
//   fifo_rinc        pop strobe per FIFO (combinational, one-hot or zero)
//   chan_en          per-FIFO enable for new grants
//   out_valid/data/src/ready  registered output handshake
//   busy             high while serving a grant
module fifo_rd_rr_arbiter #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned BURST     = 4,
  parameter int unsigned SRCW      = 2
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [NUM_FIFOS-1:0]       fifo_rempty,
  input  logic [NUM_FIFOS*DSIZE-1:0] fifo_rdata,
  output logic [NUM_FIFOS-1:0]       fifo_rinc,
  input  logic [NUM_FIFOS-1:0]       chan_en,
  output logic                       out_valid,
  output logic [DSIZE-1:0]           out_data,
  output logic [SRCW-1:0]            out_src,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int unsigned CNTW = 8;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [SRCW-1:0]   grant_q, grant_d;
  logic [SRCW-1:0]   last_grant_q, last_grant_d;
  logic [CNTW-1:0]   burst_cnt_q, burst_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DSIZE-1:0]  out_data_q, out_data_d;
  logic [SRCW-1:0]   out_src_q, out_src_d;

  logic [NUM_FIFOS-1:0] req;
  logic                 found;
  logic [SRCW-1:0]      pick;
  logic                 sel_empty;
  logic [DSIZE-1:0]     sel_data;
  logic                 pop;

  assign req = ~fifo_rempty & chan_en;

  // Round-robin pick: indices above last_grant first, then wrap from 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < int'(NUM_FIFOS); i++) begin
      if (!found && req[i] && (SRCW'(i) > last_grant_q)) begin
        found = 1'b1;
        pick  = SRCW'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FIFOS); i++) begin
      if (!found && req[i] && (SRCW'(i) <= last_grant_q)) begin
        found = 1'b1;
        pick  = SRCW'(i);
      end
    end
  end

  // Granted FIFO's empty flag and data; an out-of-range grant reads as empty.
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_FIFOS); i++) begin
      if (grant_q == SRCW'(i)) begin
        sel_empty = fifo_rempty[i];
        sel_data  = fifo_rdata[i*DSIZE +: DSIZE];
      end
    end
  end

  // Next-state, pop decision and output-stage update.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = pick;
          last_grant_d = pick;
          burst_cnt_d  = '0;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        pop = ~sel_empty & (~out_valid_q | out_ready);
        if (pop) begin
          out_data_d  = sel_data;
          out_src_d   = grant_q;
          out_valid_d = 1'b1;
          burst_cnt_d = burst_cnt_q + CNTW'(1);
        end
        // rempty is registered, so a drained FIFO is seen the cycle after its last pop.
        if ((pop && (burst_cnt_q == CNTW'(BURST - 1))) || sel_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register drains independently of the arbitration state.
    if (!pop && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pop strobe to the granted FIFO only, suppressed during reset.
  always_comb begin
    fifo_rinc = '0;
    for (int i = 0; i < int'(NUM_FIFOS); i++) begin
      fifo_rinc[i] = pop & ~rrst & (grant_q == SRCW'(i));
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRCW'(NUM_FIFOS - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == SERVE);

endmodule

// File: tb/tb_fifo_rd_rr_arbiter.sv
// Testbench for fifo_rd_rr_arbiter: behavioural FIFO model with registered
// rempty/rdata, cycle-vector table for the basic pop sequence, and directed
// sequences for round-robin order, stall, channel enable, BURST=1 and reset.
module tb_fifo_rd_rr_arbiter;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        out_ready = 1'b1;
  logic [3:0]  chan_en = 4'hF;
  logic [3:0]  fifo_rempty;
  logic [31:0] fifo_rdata;
  logic [3:0]  fifo_rinc;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        busy;

  // Second instance with BURST=1 against a constant, never-empty FIFO0.
  logic        rrst_b = 1'b1;
  logic [3:0]  fifo_rinc_b;
  logic        out_valid_b;
  logic [7:0]  out_data_b;
  logic [1:0]  out_src_b;
  logic        busy_b;

  always #5 rclk = ~rclk;

  fifo_rd_rr_arbiter u_dut (
    .rclk(rclk), .rrst(rrst), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
    .fifo_rinc(fifo_rinc), .chan_en(chan_en), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready), .busy(busy)
  );

  fifo_rd_rr_arbiter #(.BURST(1)) u_dut_b1 (
    .rclk(rclk), .rrst(rrst_b), .fifo_rempty(4'b1110), .fifo_rdata(32'hDDCCBBAA),
    .fifo_rinc(fifo_rinc_b), .chan_en(4'hF), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_src(out_src_b), .out_ready(1'b1), .busy(busy_b)
  );

  // FIFO model: circular buffers, registered empty flag and read data.
  logic [7:0] mem [4][64];
  int         wp [4] = '{0, 0, 0, 0};
  int         rp [4] = '{0, 0, 0, 0};
  logic [3:0] rempty_m = 4'hF;
  logic [7:0] rdata_m [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  assign fifo_rempty = rempty_m;
  assign fifo_rdata  = {rdata_m[3], rdata_m[2], rdata_m[1], rdata_m[0]};

  always @(posedge rclk) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rinc[i]) rp[i] = rp[i] + 1;
      rempty_m[i] <= (rp[i] == wp[i]);
      rdata_m[i]  <= mem[i][6'(rp[i])];
    end
  end

  // Monitor: accepted words, pop log and invariant violations.
  int         cyc = 0;
  int         acc_n = 0;
  int         pop_n = 0;
  int         viol = 0;
  logic [1:0] acc_src [1024];
  logic [7:0] acc_dat [1024];
  int         pop_cyc [1024];
  logic [1:0] pop_src [1024];

  always @(posedge rclk) begin
    cyc++;
    if (out_valid && out_ready && !rrst && acc_n < 1024) begin
      acc_src[acc_n] = out_src;
      acc_dat[acc_n] = out_data;
      acc_n++;
    end
    if (fifo_rinc != 4'b0000 && pop_n < 1024) begin
      pop_cyc[pop_n] = cyc;
      for (int i = 0; i < 4; i++) if (fifo_rinc[i]) pop_src[pop_n] = 2'(i);
      pop_n++;
    end
    if ((fifo_rinc & fifo_rempty) != 4'b0000) viol++;
    if ($countones(fifo_rinc) > 1) viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] d);
    mem[i][6'(wp[i])] = d;
    wp[i] = wp[i] + 1;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst = 1'b1;
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (acc_n < target && k < budget) begin
      @(negedge rclk);
      k++;
    end
    chk(name, 32'(acc_n), 32'(target));
  endtask

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] rinc;
    logic       val;
    logic [7:0] dat;
    logic [1:0] src;
    logic       bsy;
  } vec_t;

  vec_t tv [7];
  vec_t tb1 [5];

  int         t5s [5] = '{0, 1, 3, 0, 3};
  int         t5j [5] = '{0, 0, 0, 4, 4};
  int         base;
  int         pbase;
  int         k;
  logic [7:0] hold_d;
  logic [1:0] hold_s;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst rdy rinc val dat src busy
    tv[0] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1};
    tv[4] = '{1'b0, 1'b1, 4'h1, 1'b1, 8'h22, 2'd0, 1'b1};
    tv[5] = '{1'b0, 1'b1, 4'h0, 1'b1, 8'h33, 2'd0, 1'b1};
    tv[6] = '{1'b0, 1'b1, 4'h0, 1'b0, 8'h33, 2'd0, 1'b0};

    tb1[0] = '{1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tb1[1] = '{1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 1'b1};
    tb1[2] = '{1'b0, 1'b1, 4'h0, 1'b1, 8'hAA, 2'd0, 1'b0};
    tb1[3] = '{1'b0, 1'b1, 4'h1, 1'b0, 8'hAA, 2'd0, 1'b1};
    tb1[4] = '{1'b0, 1'b1, 4'h0, 1'b1, 8'hAA, 2'd0, 1'b0};

    repeat (2) @(negedge rclk);

    // Three words in FIFO0, consumer always ready.
    load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
    for (int r = 0; r < 7; r++) begin
      rrst = tv[r].rst;
      out_ready = tv[r].rdy;
      #1;
      chk($sformatf("t1_rinc_row%0d", r), 32'(fifo_rinc), 32'(tv[r].rinc));
      chk($sformatf("t1_valid_row%0d", r), 32'(out_valid), 32'(tv[r].val));
      chk($sformatf("t1_data_row%0d", r), 32'(out_data), 32'(tv[r].dat));
      chk($sformatf("t1_src_row%0d", r), 32'(out_src), 32'(tv[r].src));
      chk($sformatf("t1_busy_row%0d", r), 32'(busy), 32'(tv[r].bsy));
      @(negedge rclk);
    end

    // BURST=1: exactly one pop per grant, then back to IDLE.
    rrst_b = 1'b0;
    for (int r = 0; r < 5; r++) begin
      #1;
      chk($sformatf("b1_rinc_row%0d", r), 32'(fifo_rinc_b), 32'(tb1[r].rinc));
      chk($sformatf("b1_busy_row%0d", r), 32'(busy_b), 32'(tb1[r].bsy));
      chk($sformatf("b1_valid_row%0d", r), 32'(out_valid_b), 32'(tb1[r].val));
      chk($sformatf("b1_data_row%0d", r), 32'(out_data_b), 32'(tb1[r].dat));
      @(negedge rclk);
    end
    rrst_b = 1'b1;

    // All four FIFOs hold 8 words: 0,1,2,3,0,1,2,3 in bursts of 4.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) load(i, 8'(i * 16 + j));
    base = acc_n;
    pbase = pop_n;
    do_reset();
    wait_acc(base + 32, 300, "t2_word_count");
    repeat (10) @(negedge rclk);
    chk("t2_pop_count", 32'(pop_n - pbase), 32'd32);
    for (int n = 0; n < 32; n++) begin
      chk($sformatf("t2_src_%0d", n), 32'(acc_src[base + n]), 32'((n / 4) % 4));
      chk($sformatf("t2_dat_%0d", n), 32'(acc_dat[base + n]),
          32'(((n / 4) % 4) * 16 + (n / 16) * 4 + n % 4));
      chk($sformatf("t2_popcyc_%0d", n), 32'(pop_cyc[pbase + n] - pop_cyc[pbase]),
          32'((n / 4) * 5 + n % 4));
    end

    // Only FIFO3 non-empty after reset: search wraps to 3.
    load(3, 8'h31); load(3, 8'h32);
    base = acc_n;
    do_reset();
    wait_acc(base + 2, 40, "t3_word_count");
    chk("t3_src0", 32'(acc_src[base]), 32'd3);
    chk("t3_dat0", 32'(acc_dat[base]), 32'h31);
    chk("t3_src1", 32'(acc_src[base + 1]), 32'd3);
    chk("t3_dat1", 32'(acc_dat[base + 1]), 32'h32);

    // FIFO2 streaming with a 5-cycle consumer stall.
    for (int j = 0; j < 6; j++) load(2, 8'(8'hA0 + j));
    base = acc_n;
    do_reset();
    k = 0;
    #1;
    while (!out_valid && k < 50) begin
      @(negedge rclk);
      #1;
      k++;
    end
    chk("t4_valid_seen", 32'(out_valid), 32'd1);
    @(negedge rclk);
    out_ready = 1'b0;
    #1;
    hold_d = out_data;
    hold_s = out_src;
    chk("t4_stall_rinc_first", 32'(fifo_rinc), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge rclk);
      #1;
      chk($sformatf("t4_stall_valid_%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("t4_stall_data_%0d", c), 32'(out_data), 32'(hold_d));
      chk($sformatf("t4_stall_src_%0d", c), 32'(out_src), 32'(hold_s));
      chk($sformatf("t4_stall_rinc_%0d", c), 32'(fifo_rinc), 32'd0);
    end
    @(negedge rclk);
    out_ready = 1'b1;
    wait_acc(base + 6, 60, "t4_word_count");
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("t4_src_%0d", n), 32'(acc_src[base + n]), 32'd2);
      chk($sformatf("t4_dat_%0d", n), 32'(acc_dat[base + n]), 32'(8'hA0 + n));
    end

    // chan_en masks FIFO2; clearing chan_en[1] mid-burst lets the burst finish.
    chan_en = 4'b1011;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) load(i, 8'(8'h80 + i * 16 + j));
    base = acc_n;
    pbase = pop_n;
    do_reset();
    k = 0;
    #1;
    while (!fifo_rinc[1] && k < 100) begin
      @(negedge rclk);
      #1;
      k++;
    end
    chk("t5_fifo1_granted", 32'(fifo_rinc[1]), 32'd1);
    @(negedge rclk);
    chan_en = 4'b1001;
    wait_acc(base + 20, 300, "t5_word_count");
    repeat (20) @(negedge rclk);
    chk("t5_total_words", 32'(acc_n - base), 32'd20);
    for (int n = 0; n < 20; n++) begin
      chk($sformatf("t5_src_%0d", n), 32'(acc_src[base + n]), 32'(t5s[n / 4]));
      chk($sformatf("t5_dat_%0d", n), 32'(acc_dat[base + n]),
          32'(8'h80 + t5s[n / 4] * 16 + t5j[n / 4] + n % 4));
    end

    // Reset during a FIFO1 burst with a word pending; FIFO0 wins afterwards.
    chan_en = 4'b0011;
    for (int j = 0; j < 4; j++) load(1, 8'(8'hC0 + j));
    k = 0;
    #1;
    while (!(out_valid && out_src == 2'd1) && k < 50) begin
      @(negedge rclk);
      #1;
      k++;
    end
    chk("t6_valid_before_reset", 32'(out_valid), 32'd1);
    chk("t6_busy_before_reset", 32'(busy), 32'd1);
    @(negedge rclk);
    load(0, 8'h5A);
    rrst = 1'b1;
    #1;
    chk("t6_rinc_in_reset", 32'(fifo_rinc), 32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    #1;
    chk("t6_valid_after_reset", 32'(out_valid), 32'd0);
    chk("t6_rinc_after_reset", 32'(fifo_rinc), 32'd0);
    chk("t6_busy_after_reset", 32'(busy), 32'd0);
    @(negedge rclk);
    #1;
    chk("t6_first_grant_busy", 32'(busy), 32'd1);
    chk("t6_first_grant_fifo0", 32'(fifo_rinc), 32'h1);
    @(negedge rclk);
    #1;
    chk("t6_fifo0_word", 32'(out_data), 32'h5A);
    repeat (30) @(negedge rclk);

    chk("no_bad_pop", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
